// File: rtl/mul_div_unit.sv
// HI/LO multiply/divide unit beside EXE: pipelined MULT/MULTU, 32-step restoring DIV/DIVU, MTHI/MTLO, MFHI/MFLO.
// Holds EXE via md_stall_o until the op reaches DONE; a WB flush aborts the op and leaves HI/LO untouched.
module mul_div_unit #(
   parameter int          MUL_LAT   = 1,
   parameter logic [31:0] HILO_INIT = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        exe_valid_in,
   input  logic        exe_advance_in,
   input  logic [31:0] exe_in0_in,
   input  logic [31:0] exe_in1_in,
   input  logic [5:0]  exe_mult_div_op_in,
   input  logic        exe_read_request_in,
   input  logic        exe_read_hi_in,
   input  logic        wb_ClrStpJmp_in,
   output logic        md_stall_out,
   output logic [31:0] md_rdata_out,
   output logic        md_busy_out
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

   state_e      state_q, state_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic [31:0] a_q, a_d;      // multiplicand, or dividend magnitude shifting into quotient
   logic [31:0] b_q, b_d;      // multiplier, or divisor magnitude
   logic [31:0] rem_q, rem_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        sgn_q, sgn_d, qneg_q, qneg_d, rneg_q, rneg_d;

   logic        md_op, start;
   logic [33:0] trial;
   logic        ge;
   logic [31:0] rem_nx, quo_nx;
   logic signed [65:0] prod;
   logic        unused_ok;

   assign md_op = |exe_mult_div_op_in[3:0];
   assign start = exe_valid_in & md_op & (state_q == S_IDLE) & !wb_ClrStpJmp_in;

   // 34-bit trial keeps the borrow bit meaningful even when the shifted remainder exceeds 32 bits.
   assign trial  = {1'b0, rem_q, a_q[31]} - {2'b00, b_q};
   assign ge     = !trial[33];
   assign rem_nx = ge ? trial[31:0] : {rem_q[30:0], a_q[31]};
   assign quo_nx = {a_q[30:0], ge};
   assign prod   = $signed({sgn_q & a_q[31], a_q}) * $signed({sgn_q & b_q[31], b_q});

   always_comb begin
      state_d = state_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      a_d     = a_q;
      b_d     = b_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      sgn_d   = sgn_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               cnt_d = '0;
               rem_d = '0;
               if (exe_mult_div_op_in[3] | exe_mult_div_op_in[2]) begin
                  state_d = S_MUL;
                  sgn_d   = exe_mult_div_op_in[3];
                  a_d     = exe_in0_in;
                  b_d     = exe_in1_in;
               end else begin
                  state_d = S_DIV;
                  qneg_d  = exe_mult_div_op_in[1] & (exe_in0_in[31] ^ exe_in1_in[31]);
                  rneg_d  = exe_mult_div_op_in[1] & exe_in0_in[31];
                  a_d     = (exe_mult_div_op_in[1] & exe_in0_in[31]) ? -exe_in0_in : exe_in0_in;
                  b_d     = (exe_mult_div_op_in[1] & exe_in1_in[31]) ? -exe_in1_in : exe_in1_in;
               end
            end
            if (exe_valid_in & !wb_ClrStpJmp_in) begin
               if (exe_mult_div_op_in[5]) hi_d = exe_in0_in;
               if (exe_mult_div_op_in[4]) lo_d = exe_in0_in;
            end
         end
         S_MUL: begin
            if (cnt_q == 5'(MUL_LAT - 1)) begin
               hi_d    = prod[63:32];
               lo_d    = prod[31:0];
               cnt_d   = '0;
               state_d = S_DONE;
            end else begin
               cnt_d = cnt_q + 5'd1;
            end
         end
         S_DIV: begin
            if (b_q == '0) begin
               state_d = S_DONE;
            end else begin
               a_d   = quo_nx;
               rem_d = rem_nx;
               cnt_d = cnt_q + 5'd1;
               if (cnt_q == 5'd31) begin
                  lo_d    = qneg_q ? -quo_nx : quo_nx;
                  hi_d    = rneg_q ? -rem_nx : rem_nx;
                  cnt_d   = '0;
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            if (exe_advance_in) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (wb_ClrStpJmp_in) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         hi_d    = hi_q;
         lo_d    = lo_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         hi_q    <= HILO_INIT;
         lo_q    <= HILO_INIT;
         a_q     <= '0;
         b_q     <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         sgn_q   <= 1'b0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         a_q     <= a_d;
         b_q     <= b_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         sgn_q   <= sgn_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
      end
   end

   assign md_stall_out = exe_valid_in & md_op & (state_q != S_DONE) & !wb_ClrStpJmp_in;
   assign md_busy_out  = (state_q == S_MUL) | (state_q == S_DIV);
   assign md_rdata_out = exe_read_hi_in ? hi_q : lo_q;

   // The read request only selects the EXE result mux outside this block.
   assign unused_ok = ^{exe_read_request_in, prod[65:64]};

endmodule

// File: tb/tb_mul_div_unit.sv
// Randomized and directed bench for mul_div_unit against a plain-arithmetic HI/LO model.
module tb_mul_div_unit;
   localparam int          MUL_LAT   = 1;
   localparam logic [31:0] HILO_INIT = 32'h0000_0000;

   localparam logic [5:0] OP_MTHI = 6'b100000, OP_MTLO = 6'b010000, OP_MULT = 6'b001000,
                          OP_MULTU = 6'b000100, OP_DIV = 6'b000010, OP_DIVU = 6'b000001;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid, adv, rreq, rhi, flush;
   logic [31:0] in0, in1;
   logic [5:0]  op;
   logic        stall, busy;
   logic [31:0] rdata;

   int checks = 0;
   int errors = 0;
   logic [31:0] hi_m, lo_m;

   always #5 clk = ~clk;

   mul_div_unit #(.MUL_LAT(MUL_LAT), .HILO_INIT(HILO_INIT)) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .exe_valid_in       (valid),
      .exe_advance_in     (adv),
      .exe_in0_in         (in0),
      .exe_in1_in         (in1),
      .exe_mult_div_op_in (op),
      .exe_read_request_in(rreq),
      .exe_read_hi_in     (rhi),
      .wb_ClrStpJmp_in    (flush),
      .md_stall_out       (stall),
      .md_rdata_out       (rdata),
      .md_busy_out        (busy)
   );

   // Reference: architectural effect of one op on HI/LO and its expected stall length.
   task automatic model_op(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                           output int exp_stall);
      logic signed [63:0] sp, sq, sr;
      logic [63:0]        up, uq, ur;
      exp_stall = 0;
      case (o)
         OP_MTHI: hi_m = a;
         OP_MTLO: lo_m = a;
         OP_MULT: begin
            sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
            hi_m = sp[63:32]; lo_m = sp[31:0]; exp_stall = 1 + MUL_LAT;
         end
         OP_MULTU: begin
            up = {32'b0, a} * {32'b0, b};
            hi_m = up[63:32]; lo_m = up[31:0]; exp_stall = 1 + MUL_LAT;
         end
         OP_DIV: begin
            if (b == 0) exp_stall = 2;
            else begin
               sq = $signed({{32{a[31]}}, a}) / $signed({{32{b[31]}}, b});
               sr = $signed({{32{a[31]}}, a}) % $signed({{32{b[31]}}, b});
               lo_m = sq[31:0]; hi_m = sr[31:0]; exp_stall = 33;
            end
         end
         OP_DIVU: begin
            if (b == 0) exp_stall = 2;
            else begin
               uq = {32'b0, a} / {32'b0, b};
               ur = {32'b0, a} % {32'b0, b};
               lo_m = uq[31:0]; hi_m = ur[31:0]; exp_stall = 33;
            end
         end
         default: exp_stall = 0;
      endcase
   endtask

   task automatic check_hilo(input string name);
      rreq = 1'b1; rhi = 1'b1; #1;
      checks++;
      if (rdata !== hi_m) begin errors++; $display("FAIL %s hi: got %h expected %h", name, rdata, hi_m); end
      rhi = 1'b0; #1;
      checks++;
      if (rdata !== lo_m) begin errors++; $display("FAIL %s lo: got %h expected %h", name, rdata, lo_m); end
      rreq = 1'b0;
   endtask

   // Called at a negedge; returns at a negedge with EXE idle.
   task automatic run_op(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                         input string name);
      int exp_stall, n;
      model_op(o, a, b, exp_stall);
      valid = 1'b1; op = o; in0 = a; in1 = b; adv = 1'b0;
      n = 0;
      #1;
      while (stall === 1'b1 && n < 200) begin
         n++;
         @(negedge clk); #1;
      end
      checks++;
      if (n !== exp_stall) begin errors++; $display("FAIL %s stall: got %0d expected %0d", name, n, exp_stall); end
      adv = 1'b1;
      @(posedge clk);
      @(negedge clk);
      valid = 1'b0; op = '0; adv = 1'b0;
      check_hilo(name);
      @(negedge clk);
   endtask

   task automatic test_reset();
      checks++;
      if (stall !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL reset stall/busy: got %b/%b expected 0/0", stall, busy);
      end
      hi_m = HILO_INIT; lo_m = HILO_INIT;
      check_hilo("reset");
   endtask

   task automatic test_directed();
      run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
      run_op(OP_MULT,  32'hFFFF_FFFF, 32'h0000_0002, "mult_neg");
      run_op(OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, "div_m7_2");
      run_op(OP_DIVU,  32'd100,       32'd7,         "divu_100_7");
      run_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
      run_op(OP_DIVU,  32'h1234_5678, 32'h0,         "divu_zero");
      run_op(OP_DIV,   32'h8765_4321, 32'h0,         "div_zero");
      run_op(OP_MTHI,  32'h0000_1234, 32'h0,         "mthi");
      run_op(OP_MTLO,  32'hCAFE_F00D, 32'h0,         "mtlo");
   endtask

   task automatic test_done_hold();
      int exp_stall;
      model_op(OP_MULTU, 32'h0000_0003, 32'h0000_0005, exp_stall);
      valid = 1'b1; op = OP_MULTU; in0 = 32'h3; in1 = 32'h5; adv = 1'b0;
      repeat (1 + MUL_LAT) @(negedge clk);
      in0 = 32'h7; in1 = 32'h9;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++;
         if (stall !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL done_hold stall/busy: got %b/%b expected 0/0", stall, busy);
         end
         @(negedge clk);
      end
      adv = 1'b1;
      @(posedge clk); @(negedge clk);
      valid = 1'b0; op = '0; adv = 1'b0;
      check_hilo("done_hold");
      @(negedge clk);
   endtask

   task automatic test_flush();
      valid = 1'b1; op = OP_DIV; in0 = 32'd1000; in1 = 32'd3; adv = 1'b0;
      repeat (11) @(negedge clk);
      #1;
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL flush busy_mid: got %b expected 1", busy); end
      flush = 1'b1; #1;
      checks++;
      if (stall !== 1'b0) begin errors++; $display("FAIL flush stall: got %b expected 0", stall); end
      @(posedge clk); @(negedge clk);
      flush = 1'b0; valid = 1'b0; op = '0; #1;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL flush busy_after: got %b expected 0", busy); end
      check_hilo("flush_keep");
      @(negedge clk);
      run_op(OP_DIV, 32'hFFFF_FC18, 32'd7, "div_after_flush");
   endtask

   task automatic test_back_to_back();
      run_op(OP_MULT, 32'h7FFF_FFFF, 32'h8000_0000, "b2b_mult");
      run_op(OP_MTLO, 32'h0BAD_BEEF, 32'h0,         "b2b_mtlo");
      run_op(OP_DIVU, 32'hFFFF_FFFF, 32'h1,         "b2b_divu");
      run_op(OP_MTHI, 32'h1357_9BDF, 32'h0,         "b2b_mthi");
   endtask

   task automatic test_random();
      logic [5:0]  o;
      logic [31:0] a, b;
      for (int i = 0; i < 40; i++) begin
         o = 6'b1 << $urandom_range(0, 5);
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'h0;
            1: b = $urandom_range(1, 15);
            2: b = -($urandom_range(1, 15));
            3: a = $urandom_range(0, 255);
            default: ;
         endcase
         run_op(o, a, b, "random");
      end
   endtask

   task automatic test_reset_mid_div();
      valid = 1'b1; op = OP_DIVU; in0 = 32'hDEAD_BEEF; in1 = 32'd13; adv = 1'b0;
      repeat (6) @(negedge clk);
      valid = 1'b0; op = '0;
      #1;
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid busy_before: got %b expected 1", busy); end
      rst_n = 1'b0; #1;
      checks++;
      if (busy !== 1'b0 || stall !== 1'b0) begin
         errors++; $display("FAIL rst_mid busy/stall: got %b/%b expected 0/0", busy, stall);
      end
      hi_m = HILO_INIT; lo_m = HILO_INIT;
      check_hilo("rst_mid");
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_op(OP_DIVU, 32'd100, 32'd7, "divu_after_reset");
   endtask

   initial begin
      rst_n = 1'b0; valid = 1'b0; adv = 1'b0; rreq = 1'b0; rhi = 1'b0; flush = 1'b0;
      in0 = '0; in1 = '0; op = '0;
      hi_m = HILO_INIT; lo_m = HILO_INIT;
      repeat (2) @(posedge clk);
      @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      @(negedge clk);
      test_directed();
      test_done_hold();
      test_flush();
      test_back_to_back();
      test_random();
      test_reset_mid_div();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
